se_sram_srw_requester: RTL

Initiator-side controller for the single-read/write-port SRAM wrappers (`se_sram_srw_*`, `se_sram_srw_*_we`). It accepts read and write requests from a client over a valid/ack handshake and drives the SRAM port from registers. It tracks the one-cycle SRAM read latency and returns read data through a small response buffer, so the client can apply backpressure without losing data. It sits between a client datapath (CPU, DMA, framebuffer) and exactly one SRAM instance.

---
 rtl/se_sram_srw_pkg.sv | 22 ++
 rtl/se_sram_srw_rsp_fifo.sv | 50 +++++
 rtl/se_sram_srw_requester.sv | 83 ++++++++
 3 files changed

// File: rtl/se_sram_srw_pkg.sv
// Shared definitions for the single-port SRAM requester: read latency,
// request bundle and the read-credit rule.
package se_sram_srw_pkg;

   localparam int SRW_READ_LATENCY  = 1;
   localparam int SRW_ADDRESS_WIDTH = 16;
   localparam int SRW_DATA_WIDTH    = 32;
   localparam int SRW_WE_WIDTH      = 4;

   typedef struct packed {
      logic                         rnw;
      logic [SRW_ADDRESS_WIDTH-1:0] address;
      logic [SRW_DATA_WIDTH-1:0]    data;
      logic [SRW_WE_WIDTH-1:0]      we;
   } srw_req_t;

   // A read may issue only while every outstanding read still has a buffer slot.
   function automatic logic credit_ok(input int count, input int inflight, input int depth);
      return (count + inflight) < depth;
   endfunction

endpackage

// File: rtl/se_sram_srw_rsp_fifo.sv
// Read-response buffer: power-of-two synchronous FIFO with clock enable,
// occupancy count and asynchronous reset.
module se_sram_srw_rsp_fifo #(
   parameter int data_width = 32,
   parameter int depth      = 4
) (
   input  logic                       clock,
   input  logic                       enable,
   input  logic                       reset,
   input  logic                       push,
   input  logic [data_width-1:0]      push_data,
   input  logic                       pop,
   output logic [data_width-1:0]      head_data,
   output logic                       valid,
   output logic [$clog2(depth):0]     count
);

   localparam int AW = $clog2(depth);

   logic [data_width-1:0] mem [depth];
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic                  pop_ok;

   // Pops while empty are dropped; pushes never find the buffer full.
   assign pop_ok    = pop && (count != '0);
   assign valid     = (count != '0);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < depth; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (enable) begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/se_sram_srw_requester.sv
// Initiator for one single-port SRAM: registered issue stage, read-tag
// pipeline matching the SRAM latency, and a credit-protected response buffer.
module se_sram_srw_requester
   import se_sram_srw_pkg::*;
#(
   parameter int address_width = 16,
   parameter int data_width    = 32,
   parameter int we_width      = 4,
   parameter int rsp_depth     = 4
) (
   input  logic                     sram_clock,
   input  logic                     sram_clock__enable,
   input  logic                     reset,
   input  logic                     req_valid,
   input  logic                     req_read_not_write,
   input  logic [address_width-1:0] req_address,
   input  logic [data_width-1:0]    req_write_data,
   input  logic [we_width-1:0]      req_write_enable,
   output logic                     req_ack,
   output logic                     rsp_valid,
   output logic [data_width-1:0]    rsp_data,
   input  logic                     rsp_ack,
   output logic                     sram_select,
   output logic                     sram_read_not_write,
   output logic [address_width-1:0] sram_address,
   output logic [data_width-1:0]    sram_write_data,
   output logic [we_width-1:0]      sram_write_enable,
   input  logic [data_width-1:0]    sram_data_out
);

   localparam int TAGS = SRW_READ_LATENCY + 1;

   logic [TAGS-1:0]              read_tag;
   logic [$clog2(rsp_depth):0]   count;
   logic                         accept;
   logic                         issue;

   // Handshake: a request transfers on a rising edge where req_valid && req_ack
   // (req_ack already includes the clock enable); a response transfers on an
   // enabled edge where rsp_valid && rsp_ack. req_ack never looks at req_valid.
   assign req_ack = sram_clock__enable &&
                    (!req_read_not_write ||
                     credit_ok(int'(count), $countones(read_tag), rsp_depth));
   assign accept  = req_valid && req_ack;
   assign issue   = accept && (req_read_not_write || (req_write_enable != '0));

   always_ff @(posedge sram_clock or posedge reset) begin
      if (reset) begin
         sram_select         <= 1'b0;
         sram_read_not_write <= 1'b1;
         sram_address        <= '0;
         sram_write_data     <= '0;
         sram_write_enable   <= '0;
         read_tag            <= '0;
      end else if (sram_clock__enable) begin
         sram_select <= issue;
         if (accept) begin
            sram_read_not_write <= req_read_not_write;
            sram_address        <= req_address;
            sram_write_data     <= req_write_data;
            sram_write_enable   <= req_write_enable;
         end
         // read_tag[0] is S1, the top bit is the stage whose data is on sram_data_out.
         read_tag <= {read_tag[TAGS-2:0], accept && req_read_not_write};
      end
   end

   se_sram_srw_rsp_fifo #(
      .data_width (data_width),
      .depth      (rsp_depth)
   ) u_rsp_fifo (
      .clock     (sram_clock),
      .enable    (sram_clock__enable),
      .reset     (reset),
      .push      (read_tag[TAGS-1]),
      .push_data (sram_data_out),
      .pop       (rsp_ack),
      .head_data (rsp_data),
      .valid     (rsp_valid),
      .count     (count)
   );

endmodule
